// File: rtl/rtob_sched_pkg.sv
// Shared types for the RTOB write scheduler: run-control states and the
// 128-bit {timestamp, payload} word layout.
package rtob_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        HALT  = 3'd2,
        FLUSH = 3'd3
    } sched_state_t;

    localparam int TS_MSB = 127;
    localparam int TS_LSB = 64;

    typedef struct packed {
        logic [TS_MSB-TS_LSB:0] timestamp;
        logic [TS_LSB-1:0]      payload;
    } rtob_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after rr_ptr,
// wrapping modulo NUM_REQ. Grant is one-hot or zero.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_LEN = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_LEN-1:0] rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_LEN-1:0] grant_idx,
    output logic               grant_valid
);

    int unsigned        cand;
    logic [IDX_LEN-1:0] cidx;
    logic               found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cidx      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cidx = IDX_LEN'(cand);
            if (!found && req_valid[cidx]) begin
                found     = 1'b1;
                grant_idx = cidx;
            end
        end
        grant_valid = found && enable;
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rtob_write_sched.sv
// Write arbiter and run-control sequencer in front of one RTOB core:
// round-robin merge of requester words, flush/auto_start control, sticky errors.
module rtob_write_sched
    import rtob_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int REQ_IDX_LEN   = 2,
    parameter int FLUSH_CYCLES  = 4,
    parameter int HALT_ON_ERROR = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*128-1:0]   req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     cmd_start,
    input  logic                     cmd_stop,
    input  logic                     cmd_flush,
    output logic                     core_write,
    output logic [127:0]             core_fifo_din,
    output logic                     core_flush,
    output logic                     core_auto_start,
    input  logic                     core_full,
    input  logic                     core_empty,
    input  logic                     core_timestamp_error,
    input  logic                     core_overflow_error,
    output logic [2:0]               state,
    output logic [REQ_IDX_LEN-1:0]   last_grant,
    output logic                     sticky_ts_err,
    output logic                     sticky_ovf_err,
    output logic [31:0]              accept_count
);

    localparam int CNT_W        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;

    sched_state_t             state_q, state_d;
    logic [CNT_W-1:0]         flush_cnt_q, flush_cnt_d;
    logic [REQ_IDX_LEN-1:0]   rr_ptr_q;
    logic [REQ_IDX_LEN-1:0]   grant_idx;
    logic [NUM_REQ-1:0]       grant;
    logic                     accept_en;
    logic                     accept;
    logic                     any_err;
    rtob_word_t               word_q;
    logic                     unused_status;

    assign unused_status = core_empty;
    assign any_err       = core_timestamp_error || core_overflow_error;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_LEN (REQ_IDX_LEN)
    ) u_arb (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr_q),
        .enable      (accept_en),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (accept)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // flush_cnt holds the FLUSH cycles still to come after the current one;
    // a repeated cmd_flush restarts the window counting the current cycle.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_flush) begin
                    state_d     = FLUSH;
                    flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
                end else if (!cmd_stop && cmd_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cmd_flush) begin
                    state_d     = FLUSH;
                    flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
                end else if ((HALT_ON_ERROR != 0) && any_err) begin
                    state_d = HALT;
                end else if (cmd_stop) begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                if (cmd_flush) begin
                    state_d     = FLUSH;
                    flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cmd_flush) begin
                    if (FLUSH_CYCLES > 1) begin
                        flush_cnt_d = CNT_W'(FLUSH_RELOAD);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (flush_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        core_flush      = (state_q == FLUSH);
        core_auto_start = (state_q == RUN);
        accept_en       = ((state_q == IDLE) || (state_q == RUN)) &&
                          !core_full && !core_flush && !reset;
    end

    assign req_ready     = grant;
    assign state         = state_q;
    assign core_fifo_din = word_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            core_write     <= 1'b0;
            word_q         <= '0;
            rr_ptr_q       <= '0;
            last_grant     <= '0;
            sticky_ts_err  <= 1'b0;
            sticky_ovf_err <= 1'b0;
            accept_count   <= '0;
        end else begin
            core_write <= accept;
            if (accept) begin
                word_q     <= rtob_word_t'(req_data[int'(grant_idx)*128 +: 128]);
                last_grant <= grant_idx;
                if (grant_idx == REQ_IDX_LEN'(NUM_REQ - 1)) begin
                    rr_ptr_q <= '0;
                end else begin
                    rr_ptr_q <= grant_idx + 1'b1;
                end
            end
            if (cmd_flush) begin
                sticky_ts_err  <= 1'b0;
                sticky_ovf_err <= 1'b0;
                accept_count   <= '0;
            end else begin
                if (state_q != FLUSH) begin
                    if (core_timestamp_error) sticky_ts_err  <= 1'b1;
                    if (core_overflow_error)  sticky_ovf_err <= 1'b1;
                end
                if (accept && (accept_count != '1)) begin
                    accept_count <= accept_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rtob_write_sched.sv
// Bench for rtob_write_sched: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural model.
module tb_rtob_write_sched;

    localparam int NR  = 4;
    localparam int FC  = 4;
    localparam int HOE = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*128-1:0] req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              cmd_start = 1'b0, cmd_stop = 1'b0, cmd_flush = 1'b0;
    logic              core_write;
    logic [127:0]      core_fifo_din;
    logic              core_flush, core_auto_start;
    logic              core_full = 1'b0, core_empty = 1'b0;
    logic              ts_err = 1'b0, ovf_err = 1'b0;
    logic [2:0]        state;
    logic [1:0]        last_grant;
    logic              sticky_ts_err, sticky_ovf_err;
    logic [31:0]       accept_count;

    rtob_write_sched #(
        .NUM_REQ       (NR),
        .REQ_IDX_LEN   (2),
        .FLUSH_CYCLES  (FC),
        .HALT_ON_ERROR (HOE)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_data             (req_data),
        .req_ready            (req_ready),
        .cmd_start            (cmd_start),
        .cmd_stop             (cmd_stop),
        .cmd_flush            (cmd_flush),
        .core_write           (core_write),
        .core_fifo_din        (core_fifo_din),
        .core_flush           (core_flush),
        .core_auto_start      (core_auto_start),
        .core_full            (core_full),
        .core_empty           (core_empty),
        .core_timestamp_error (ts_err),
        .core_overflow_error  (ovf_err),
        .state                (state),
        .last_grant           (last_grant),
        .sticky_ts_err        (sticky_ts_err),
        .sticky_ovf_err       (sticky_ovf_err),
        .accept_count         (accept_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int flush_seen = 0;

    // Reference model: state as spec numbers, remaining flush cycles, pointer.
    int           seq [NR];
    int           m_state = 0;
    int           m_left  = 0;
    int           m_rr    = 0;
    int           m_last  = 0;
    bit           m_write = 1'b0;
    logic [127:0] m_din   = '0;
    bit           m_ts = 1'b0, m_ovf = 1'b0;
    int unsigned  m_count = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [127:0] word_of(input int i, input int s);
        return {32'h7100_0000 | 32'(i), 32'(s), (32'(s) * 32'h9E37_79B9) ^ 32'(i), 32'(i * 4096 + s)};
    endfunction

    task automatic drive_data();
        for (int i = 0; i < NR; i++) req_data[i*128 +: 128] = word_of(i, seq[i]);
    endtask

    function automatic int model_grant();
        int idx;
        if (reset || core_full || !(m_state == 0 || m_state == 1)) return -1;
        for (int k = 0; k < NR; k++) begin
            idx = (m_rr + k) % NR;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        if (reset) begin
            m_state = 0; m_left = 0; m_rr = 0; m_last = 0;
            m_write = 1'b0; m_din = '0; m_ts = 1'b0; m_ovf = 1'b0; m_count = 0;
        end else begin
            m_write = (g >= 0);
            if (g >= 0) begin
                m_din = word_of(g, seq[g]);
                seq[g]++;
                m_rr = (g + 1) % NR;
                m_last = g;
            end
            if (cmd_flush) begin
                m_ts = 1'b0; m_ovf = 1'b0; m_count = 0;
            end else begin
                if (m_state != 3) begin
                    m_ts  = m_ts  | ts_err;
                    m_ovf = m_ovf | ovf_err;
                end
                if (g >= 0 && m_count != 32'hFFFF_FFFF) m_count++;
            end
            case (m_state)
                0: if (cmd_flush) begin m_state = 3; m_left = FC; end
                   else if (!cmd_stop && cmd_start) m_state = 1;
                1: if (cmd_flush) begin m_state = 3; m_left = FC; end
                   else if (HOE != 0 && (ts_err || ovf_err)) m_state = 2;
                   else if (cmd_stop) m_state = 0;
                2: if (cmd_flush) begin m_state = 3; m_left = FC; end
                default: begin
                    if (cmd_flush) m_left = FC - 1;
                    else m_left = m_left - 1;
                    if (m_left == 0) m_state = 0;
                end
            endcase
        end
    endtask

    task automatic step();
        logic [NR-1:0] exp_ready;
        int g;
        #2;
        g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        if (core_flush === 1'b1) flush_seen++;
        if (chk_en) begin
            check("req_ready", req_ready, exp_ready);
            check("state", state, m_state);
            check("core_write", core_write, m_write);
            check("core_fifo_din", core_fifo_din, m_din);
            check("core_flush", core_flush, m_state == 3);
            check("core_auto_start", core_auto_start, m_state == 1);
            check("last_grant", last_grant, m_last);
            check("sticky_ts_err", sticky_ts_err, m_ts);
            check("sticky_ovf_err", sticky_ovf_err, m_ovf);
            check("accept_count", accept_count, m_count);
        end
        @(posedge clk);
        model_update(g);
        #1;
        drive_data();
    endtask

    task automatic pulse_start(); cmd_start = 1'b1; step(); cmd_start = 1'b0; endtask
    task automatic pulse_flush(); cmd_flush = 1'b1; step(); cmd_flush = 1'b0; endtask

    initial begin
        for (int i = 0; i < NR; i++) seq[i] = 0;
        drive_data();
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;

        // Back-to-back grants 0,1,2,3,0 in IDLE.
        req_valid = 4'b1111;
        repeat (5) step();
        check("count_after_5", accept_count, 5);
        check("grant_5th", last_grant, 0);
        req_valid = 4'b0000;
        step();

        // core_full window.
        req_valid = 4'b0101;
        core_full = 1'b1;
        repeat (3) step();
        core_full = 1'b0;
        repeat (4) step();
        req_valid = 4'b0000;

        // Error halt, ignored start, flush.
        pulse_start();
        ts_err = 1'b1; step(); ts_err = 1'b0;
        step();
        pulse_start();
        check("halt_state", state, 2);
        check("halt_autostart", core_auto_start, 0);
        check("halt_sticky", sticky_ts_err, 1);
        flush_seen = 0;
        pulse_flush();
        repeat (6) step();
        check("flush_len", flush_seen, FC);
        check("flush_sticky", sticky_ts_err, 0);
        check("flush_count", accept_count, 0);

        // Flush+stop in RUN, flush reissued in 2nd flush cycle.
        pulse_start();
        flush_seen = 0;
        cmd_flush = 1'b1; cmd_stop = 1'b1; step(); cmd_stop = 1'b0; cmd_flush = 1'b0;
        step();
        pulse_flush();
        repeat (6) step();
        check("reflush_len", flush_seen, FC + 1);

        // Reset right after an accept.
        req_valid = 4'b1111;
        step();
        reset = 1'b1;
        step();
        check("rst_write", core_write, 0);
        check("rst_state", state, 0);
        check("rst_din", core_fifo_din, 0);
        reset = 1'b0;

        // Single requester, then fairness with requester 0.
        req_valid = 4'b0100;
        repeat (10) step();
        check("solo_grant", last_grant, 2);
        req_valid = 4'b0101;
        repeat (6) step();

        // Randomized traffic and control.
        for (int c = 0; c < 3000; c++) begin
            req_valid  = 4'($urandom);
            core_full  = ($urandom_range(99) < 25);
            core_empty = 1'($urandom);
            cmd_start  = ($urandom_range(99) < 8);
            cmd_stop   = ($urandom_range(99) < 4);
            cmd_flush  = ($urandom_range(99) < 3);
            ts_err     = ($urandom_range(99) < 3);
            ovf_err    = ($urandom_range(99) < 3);
            reset      = ($urandom_range(199) == 0);
            step();
        end
        reset = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_flush = 1'b0;
        ts_err = 1'b0; ovf_err = 1'b0; core_full = 1'b0; req_valid = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
